// File: rtl/mul16_pkg.sv
// Shared constants, state encoding and operand payload for the sequential 16x16 multiplier.
package mul16_pkg;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = 4'd15;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } operands_t;

  // Step counter increment as a half-adder chain, keeping the shared adder the only adder.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    logic          carry;
    logic [CW-1:0] r;
    carry = 1'b1;
    for (int i = 0; i < int'(CW); i++) begin
      r[i]  = c[i] ^ carry;
      carry = c[i] & carry;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul16_seq_add16.sv
// Add16 ripple-carry adder; the carry-out is not exported since all sums wrap modulo 2^16.
module mul16_seq_add16
  import mul16_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/mul16_seq.sv
// Sequential shift-and-add 16x16 multiplier (low 16 bits) with valid/ready on both sides.
module mul16_seq
  import mul16_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         busy
);

  state_t          state;
  state_t          state_next;
  operands_t       ops;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    acc;
  logic [W-1:0]    addend;
  logic [W-1:0]    sum;
  logic [CW-1:0]   cnt;

  assign ops    = {a, b};
  // Partial product gate: multiplicand passes only when the current multiplier bit is set.
  assign addend = a_reg & {W{b_reg[0]}};

  mul16_seq_add16 u_add16 (
    .a   (acc),
    .b   (addend),
    .sum (sum)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid)          state_next = S_RUN;
      S_RUN:   if (cnt == LAST_CNT)   state_next = S_DONE;
      S_DONE:  if (out_ready)         state_next = S_IDLE;
      default:                        state_next = S_IDLE;
    endcase
  end

  // State, datapath and handshake flags; flags follow the next state so they are plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == S_IDLE);
      busy      <= (state_next == S_RUN);
      out_valid <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= ops.a;
            b_reg <= ops.b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          acc   <= sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt_inc(cnt);
          if (cnt == LAST_CNT) out <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule
